// File: rtl/rr_prior_arbiter.sv
// Round-robin arbiter built on MSB-first leading-one selection.
// A grant is held until the owner raises done_in or the hold counter
// reaches MAX_HOLD. On release, the next owner is granted at the same
// edge. The search first looks strictly below the last owner, then falls
// back to the full request vector.
module rr_prior_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_WIDTH = $clog2(NUM_REQ) + 1,
    parameter int MAX_HOLD  = 256,
    parameter int CNT_WIDTH = $clog2(MAX_HOLD) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_in,
    input  logic                 done_in,
    output logic [NUM_REQ-1:0]   gnt_out,
    output logic [IDX_WIDTH-1:0] gnt_idx_out,
    output logic                 gnt_valid_out,
    output logic                 timeout_out
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-based index of the highest set bit; 0 when the vector is empty.
    function automatic logic [IDX_WIDTH-1:0] lead_one(input logic [NUM_REQ-1:0] vec);
        logic [IDX_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res = vec[i] ? IDX_WIDTH'(i + 1) : res;
        end
        return res;
    endfunction

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   mask_s;
    logic [NUM_REQ-1:0]   masked_s;
    logic [IDX_WIDTH-1:0] sel_s;
    logic [NUM_REQ-1:0]   sel_onehot_s;
    logic                 hold_expired_s;

    // Candidate selection: requesters strictly below the last owner first,
    // then the whole vector. ptr of 0 or 1 yields an empty mask, so the
    // post-reset case naturally falls through to the full search.
    always_comb begin
        mask_s       = '0;
        sel_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_s[i] = (IDX_WIDTH'(i + 1) < ptr_q);
        end
        masked_s = req_in & mask_s;
        if (|masked_s) begin
            sel_s = lead_one(masked_s);
        end else begin
            sel_s = lead_one(req_in);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_onehot_s[i] = (sel_s == IDX_WIDTH'(i + 1));
        end
        hold_expired_s = (cnt_q >= CNT_WIDTH'(MAX_HOLD));
    end

    // Next-state and registered-output computation for the IDLE/GRANT FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_s != '0) begin
                    state_d = GRANT;
                    gnt_d   = sel_onehot_s;
                    idx_d   = sel_s;
                    valid_d = 1'b1;
                    ptr_d   = sel_s;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (done_in || hold_expired_s) begin
                    // done_in takes precedence: no timeout pulse when both coincide
                    timeout_d = ~done_in;
                    if (sel_s != '0) begin
                        state_d = GRANT;
                        gnt_d   = sel_onehot_s;
                        idx_d   = sel_s;
                        valid_d = 1'b1;
                        ptr_d   = sel_s;
                        cnt_d   = CNT_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    if (cnt_q < CNT_WIDTH'(MAX_HOLD)) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                ptr_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt_out       = gnt_q;
    assign gnt_idx_out   = idx_q;
    assign gnt_valid_out = valid_q;
    assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_rr_prior_arbiter.sv
// Directed, table-driven bench for rr_prior_arbiter (MAX_HOLD=4).
module tb_rr_prior_arbiter;

    localparam int N  = 8;
    localparam int IW = $clog2(N) + 1;
    localparam int MH = 4;
    localparam int CW = $clog2(MH) + 1;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_in;
    logic          done_in;
    logic [N-1:0]  gnt_out;
    logic [IW-1:0] gnt_idx_out;
    logic          gnt_valid_out;
    logic          timeout_out;

    int n_tests;
    int n_fail;

    rr_prior_arbiter #(
        .NUM_REQ  (N),
        .IDX_WIDTH(IW),
        .MAX_HOLD (MH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .done_in      (done_in),
        .gnt_out      (gnt_out),
        .gnt_idx_out  (gnt_idx_out),
        .gnt_valid_out(gnt_valid_out),
        .timeout_out  (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        int           exp_idx;
        logic         exp_to;
    } vec_t;

    vec_t vecs[29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against an expected one-based index and timeout flag.
    task automatic check_all(input string tag, input int exp_idx, input logic exp_to);
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        if (exp_idx != 0) exp_gnt[exp_idx-1] = 1'b1;
        check({tag, ".idx"},     32'(gnt_idx_out),   32'(exp_idx));
        check({tag, ".gnt"},     32'(gnt_out),       32'(exp_gnt));
        check({tag, ".valid"},   32'(gnt_valid_out), 32'(exp_idx != 0));
        check({tag, ".timeout"}, 32'(timeout_out),   32'(exp_to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req_in  = 8'h00;
        done_in = 1'b0;

        // {req, done, expected one-based idx, expected timeout}
        vecs[0]  = '{8'b1001_0100, 1'b0, 8, 1'b0}; // first grant picks MSB
        vecs[1]  = '{8'hFF, 1'b1, 7, 1'b0};         // rotation, back-to-back
        vecs[2]  = '{8'hFF, 1'b1, 6, 1'b0};
        vecs[3]  = '{8'hFF, 1'b1, 5, 1'b0};
        vecs[4]  = '{8'hFF, 1'b1, 4, 1'b0};
        vecs[5]  = '{8'hFF, 1'b1, 3, 1'b0};
        vecs[6]  = '{8'hFF, 1'b1, 2, 1'b0};
        vecs[7]  = '{8'hFF, 1'b1, 1, 1'b0};
        vecs[8]  = '{8'hFF, 1'b1, 8, 1'b0};         // wrap to top
        vecs[9]  = '{8'b0000_0100, 1'b1, 3, 1'b0};
        vecs[10] = '{8'b0100_0100, 1'b1, 7, 1'b0};  // masked empty -> full search
        vecs[11] = '{8'b0001_0000, 1'b1, 5, 1'b0};
        vecs[12] = '{8'b0000_0010, 1'b0, 5, 1'b0};  // owner withdrew, grant held
        vecs[13] = '{8'b0000_0010, 1'b0, 5, 1'b0};
        vecs[14] = '{8'b0000_0010, 1'b1, 2, 1'b0};
        vecs[15] = '{8'b0000_0011, 1'b1, 1, 1'b0};  // hold cycle 1
        vecs[16] = '{8'b0000_0011, 1'b0, 1, 1'b0};  // 2
        vecs[17] = '{8'b0000_0011, 1'b0, 1, 1'b0};  // 3
        vecs[18] = '{8'b0000_0011, 1'b0, 1, 1'b0};  // 4
        vecs[19] = '{8'b0000_0011, 1'b0, 2, 1'b1};  // forced release + pulse
        vecs[20] = '{8'b0000_0011, 1'b0, 2, 1'b0};  // pulse lasts one cycle
        vecs[21] = '{8'b0000_0011, 1'b0, 2, 1'b0};
        vecs[22] = '{8'b0000_0011, 1'b0, 2, 1'b0};
        vecs[23] = '{8'b0000_0011, 1'b1, 1, 1'b0};  // done at limit: no pulse
        vecs[24] = '{8'b0000_0000, 1'b1, 0, 1'b0};  // release to idle
        vecs[25] = '{8'b0000_0000, 1'b1, 0, 1'b0};  // done ignored while idle
        vecs[26] = '{8'b0000_0001, 1'b0, 1, 1'b0};
        vecs[27] = '{8'b0000_0001, 1'b1, 1, 1'b0};  // sole requester re-granted
        vecs[28] = '{8'b0000_0010, 1'b1, 2, 1'b0};

        #1;
        check_all("reset", 0, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            check_all($sformatf("idle%0d", i), 0, 1'b0);
        end

        for (int i = 0; i < 29; i++) begin
            req_in  = vecs[i].req;
            done_in = vecs[i].done;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_to);
        end

        // Asynchronous reset between edges while requester 1 owns the grant.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 1'b0);
        #1;
        rst_n   = 1'b1;
        req_in  = 8'b0000_0011;
        done_in = 1'b0;
        // A stale ptr of 2 would pick requester 0; a cleared ptr picks requester 1.
        step();
        check_all("post_rst", 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
